// File: rtl/sisc_pkg.sv
// Shared definitions for the multi-cycle SISC core: opcodes, ALU selectors, FSM states, flag positions.
package sisc_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ALU  = 4'd1;
  localparam logic [3:0] OP_ALUI = 4'd2;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_LOD  = 4'd8;
  localparam logic [3:0] OP_STR  = 4'd9;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_SHR = 4'd6;
  localparam logic [3:0] ALU_NOT = 4'd7;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/sisc_rf.sv
// Register file: two asynchronous read ports, one synchronous write port, R0 and indices >= NREG read as zero.
module sisc_rf
  import sisc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic [3:0]        raddr_a,
  input  logic [3:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_r [16];

  function automatic logic idx_live(input logic [3:0] idx);
    return (idx != 4'd0) && ({1'b0, idx} < 5'(NREG));
  endfunction

  assign rdata_a = idx_live(raddr_a) ? regs_r[raddr_a] : '0;
  assign rdata_b = idx_live(raddr_b) ? regs_r[raddr_b] : '0;

  // Register storage with synchronous clear; writes to dead indices are dropped
  always_ff @(posedge clk) begin
    if (rst_f) begin
      for (int i = 0; i < 16; i++) regs_r[i] <= '0;
    end else if (we && idx_live(waddr)) begin
      regs_r[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/sisc_mc_core.sv
// Multi-cycle SISC core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with inline ALU, PC, IR and status
// register; instruction and data memories are reached through req/ready handshakes with wait states.
module sisc_mc_core
  import sisc_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 16,
  parameter int          NREG     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic [3:0]        stat_out,
  output logic              halted
);

  localparam int SH_W = $clog2(DATA_W);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [31:0]       ir_r, ir_s;
  logic [DATA_W-1:0] a_r, a_s, b_r, b_s, res_r, res_s;
  logic [3:0]        stat_r, stat_s;
  logic              imem_req_r, imem_req_s;
  logic              dmem_req_r, dmem_req_s, dmem_we_r, dmem_we_s;
  logic [ADDR_W-1:0] dmem_addr_r, dmem_addr_s;
  logic [DATA_W-1:0] dmem_wdata_r, dmem_wdata_s;
  logic              halted_r, halted_s;

  logic [3:0]        op_s, mm_s, rd_s, rs_s, rt_s;
  logic [DATA_W-1:0] imm_sext_s, rf_a_s, rf_b_s;
  logic [DATA_W-1:0] alu_b_s, alu_res_s;
  logic [DATA_W:0]   add_s, sub_s;
  logic [3:0]        alu_flags_s;
  logic              br_take_s, rf_we_s;

  assign op_s       = ir_r[31:28];
  assign mm_s       = ir_r[27:24];
  assign rd_s       = ir_r[23:20];
  assign rs_s       = ir_r[19:16];
  assign rt_s       = ir_r[15:12];
  assign imm_sext_s = DATA_W'($signed(ir_r[15:0]));
  assign br_take_s  = ((stat_r & mm_s) != 4'b0000) || (mm_s == 4'b0000);
  assign rf_we_s    = (state_r == ST_WB);

  sisc_rf #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clk     (clk),
    .rst_f   (rst_f),
    .raddr_a (rs_s),
    .raddr_b ((op_s == OP_STR) ? rd_s : rt_s),
    .rdata_a (rf_a_s),
    .rdata_b (rf_b_s),
    .we      (rf_we_s),
    .waddr   (rd_s),
    .wdata   (res_r)
  );

  assign alu_b_s = (op_s == OP_ALUI) ? imm_sext_s : b_r;
  assign add_s   = {1'b0, a_r} + {1'b0, alu_b_s};
  assign sub_s   = {1'b0, a_r} - {1'b0, alu_b_s};

  // ALU result and flags; carry/overflow only meaningful for ADD and SUB
  always_comb begin
    alu_res_s   = alu_b_s;
    alu_flags_s = 4'b0000;
    case (mm_s)
      ALU_ADD: begin
        alu_res_s           = add_s[DATA_W-1:0];
        alu_flags_s[FLAG_C] = add_s[DATA_W];
        alu_flags_s[FLAG_V] = (a_r[DATA_W-1] == alu_b_s[DATA_W-1]) && (add_s[DATA_W-1] != a_r[DATA_W-1]);
      end
      ALU_SUB: begin
        alu_res_s           = sub_s[DATA_W-1:0];
        alu_flags_s[FLAG_C] = sub_s[DATA_W];
        alu_flags_s[FLAG_V] = (a_r[DATA_W-1] != alu_b_s[DATA_W-1]) && (sub_s[DATA_W-1] != a_r[DATA_W-1]);
      end
      ALU_AND: alu_res_s = a_r & alu_b_s;
      ALU_OR:  alu_res_s = a_r | alu_b_s;
      ALU_XOR: alu_res_s = a_r ^ alu_b_s;
      ALU_SHL: alu_res_s = a_r << alu_b_s[SH_W-1:0];
      ALU_SHR: alu_res_s = a_r >> alu_b_s[SH_W-1:0];
      ALU_NOT: alu_res_s = ~a_r;
      default: alu_res_s = alu_b_s;
    endcase
    alu_flags_s[FLAG_Z] = (alu_res_s == '0);
    alu_flags_s[FLAG_N] = alu_res_s[DATA_W-1];
  end

  // Next-state and next-register logic; every request is raised on the edge entering its state
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    ir_s         = ir_r;
    a_s          = a_r;
    b_s          = b_r;
    res_s        = res_r;
    stat_s       = stat_r;
    imem_req_s   = imem_req_r;
    dmem_req_s   = dmem_req_r;
    dmem_we_s    = dmem_we_r;
    dmem_addr_s  = dmem_addr_r;
    dmem_wdata_s = dmem_wdata_r;
    halted_s     = halted_r;
    case (state_r)
      ST_FETCH: begin
        if (imem_req_r && imem_ready) begin
          ir_s       = imem_rdata;
          pc_s       = pc_r + ADDR_W'(1);
          imem_req_s = 1'b0;
          state_s    = ST_DECODE;
        end else begin
          imem_req_s = 1'b1;
        end
      end
      ST_DECODE: begin
        a_s     = rf_a_s;
        b_s     = rf_b_s;
        state_s = ST_EXEC;
      end
      ST_EXEC: begin
        state_s    = ST_FETCH;
        imem_req_s = 1'b1;
        case (op_s)
          OP_ALU, OP_ALUI: begin
            res_s      = alu_res_s;
            stat_s     = alu_flags_s;
            imem_req_s = 1'b0;
            state_s    = ST_WB;
          end
          OP_BRA: begin
            if (br_take_s) pc_s = ADDR_W'(ir_r[15:0]);
            else           pc_s = pc_r;
          end
          OP_BRR: begin
            if (br_take_s) pc_s = pc_r + ADDR_W'(imm_sext_s);
            else           pc_s = pc_r;
          end
          OP_LOD, OP_STR: begin
            dmem_addr_s  = ADDR_W'(a_r + imm_sext_s);
            dmem_we_s    = (op_s == OP_STR);
            dmem_wdata_s = b_r;
            dmem_req_s   = 1'b1;
            imem_req_s   = 1'b0;
            state_s      = ST_MEM;
          end
          OP_HLT: begin
            halted_s   = 1'b1;
            imem_req_s = 1'b0;
            state_s    = ST_HALT;
          end
          OP_NOP:  state_s = ST_FETCH;
          default: state_s = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (dmem_req_r && dmem_ready) begin
          dmem_req_s = 1'b0;
          dmem_we_s  = 1'b0;
          if (op_s == OP_LOD) begin
            res_s   = dmem_rdata;
            state_s = ST_WB;
          end else begin
            imem_req_s = 1'b1;
            state_s    = ST_FETCH;
          end
        end else begin
          dmem_req_s = 1'b1;
        end
      end
      ST_WB: begin
        imem_req_s = 1'b1;
        state_s    = ST_FETCH;
      end
      ST_HALT: begin
        halted_s = 1'b1;
        state_s  = ST_HALT;
      end
      default: begin
        imem_req_s = 1'b1;
        state_s    = ST_FETCH;
      end
    endcase
  end

  // Architectural and handshake registers; reset abandons any pending transaction
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_r      <= ST_FETCH;
      pc_r         <= RESET_PC;
      ir_r         <= 32'h0000_0000;
      a_r          <= '0;
      b_r          <= '0;
      res_r        <= '0;
      stat_r       <= 4'b0000;
      imem_req_r   <= 1'b0;
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= '0;
      dmem_wdata_r <= '0;
      halted_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      ir_r         <= ir_s;
      a_r          <= a_s;
      b_r          <= b_s;
      res_r        <= res_s;
      stat_r       <= stat_s;
      imem_req_r   <= imem_req_s;
      dmem_req_r   <= dmem_req_s;
      dmem_we_r    <= dmem_we_s;
      dmem_addr_r  <= dmem_addr_s;
      dmem_wdata_r <= dmem_wdata_s;
      halted_r     <= halted_s;
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = pc_r;
  assign dmem_req   = dmem_req_r;
  assign dmem_we    = dmem_we_r;
  assign dmem_addr  = dmem_addr_r;
  assign dmem_wdata = dmem_wdata_r;
  assign stat_out   = stat_r;
  assign halted     = halted_r;

endmodule

// File: tb/tb_sisc_mc_core.sv
// Directed bench for sisc_mc_core: the bench plays instruction and data memory and checks every handshake.
module tb_sisc_mc_core;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted;
  logic [15:0] imem_addr, dmem_addr;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata;
  logic [3:0]  stat_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_fetch = 0;
  int t_last = 0;

  sisc_mc_core #(.DATA_W(32), .ADDR_W(16), .NREG(8), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .stat_out   (stat_out),
    .halted     (halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [15:0] imm);
    return {op, mm, rd, rs, imm};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serve one instruction fetch after 'waits' wait states, checking request and address stability
  task automatic fetch(input logic [31:0] instr, input int waits, input logic [15:0] pc);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("imem_req", {63'd0, imem_req}, 64'd1);
    check("imem_addr", {48'd0, imem_addr}, {48'd0, pc});
    check("no_dmem_in_fetch", {63'd0, dmem_req}, 64'd0);
    t_last  = t_fetch;
    t_fetch = cyc;
    repeat (waits) begin
      @(negedge clk);
      check("imem_hold", {47'd0, imem_req, imem_addr}, {47'd0, 1'b1, pc});
    end
    imem_rdata = instr;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  // Serve one data access after 'waits' wait states
  task automatic mem(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int waits);
    int n;
    logic [63:0] exp_bus;
    n = 0;
    while (dmem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("dmem_req", {63'd0, dmem_req}, 64'd1);
    check("dmem_we", {63'd0, dmem_we}, {63'd0, we});
    check("dmem_addr", {48'd0, dmem_addr}, {48'd0, addr});
    check("no_imem_in_mem", {63'd0, imem_req}, 64'd0);
    if (we) check("dmem_wdata", {32'd0, dmem_wdata}, {32'd0, wdata});
    exp_bus = {14'd0, 1'b1, we, addr, dmem_wdata};
    repeat (waits) begin
      @(negedge clk);
      check("dmem_hold", {14'd0, dmem_req, dmem_we, dmem_addr, dmem_wdata}, exp_bus);
    end
    dmem_rdata = rdata;
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0BAD_F00D;
  endtask

  initial begin
    rst_f      = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'h0000_0000;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0000_0000;
    wait_n(2);
    check("rst_req", {62'd0, imem_req, dmem_req}, 64'd0);
    check("rst_pc", {48'd0, imem_addr}, 64'd0);
    check("rst_stat", {60'd0, stat_out}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    rst_f = 1'b0;

    // Build R1 = 0x7FFFFFFF, then R2 = R1 + 1 overflows into the sign bit
    fetch(enc(4'd2, 4'd0, 4'd1, 4'd0, 16'hFFFF), 0, 16'h0000);
    wait_n(2);
    check("stat_addi_m1", {60'd0, stat_out}, {60'd0, 4'b0010});
    fetch(enc(4'd2, 4'd6, 4'd1, 4'd1, 16'h0001), 0, 16'h0001);
    wait_n(2);
    check("stat_shr", {60'd0, stat_out}, {60'd0, 4'b0000});
    fetch(enc(4'd2, 4'd0, 4'd2, 4'd1, 16'h0001), 0, 16'h0002);
    wait_n(2);
    check("stat_addi_ovf", {60'd0, stat_out}, {60'd0, 4'b0110});

    // Store R2, load it back into R6 with wait states, store R6
    fetch(enc(4'd9, 4'd0, 4'd2, 4'd0, 16'h0010), 0, 16'h0003);
    check("lat_alu", 64'(t_fetch - t_last), 64'd4);
    mem(1'b1, 16'h0010, 32'h8000_0000, 32'h0, 0);
    fetch(enc(4'd8, 4'd0, 4'd6, 4'd0, 16'h0010), 3, 16'h0004);
    check("lat_str", 64'(t_fetch - t_last), 64'd4);
    mem(1'b0, 16'h0010, 32'h0, 32'h8000_0000, 2);
    fetch(enc(4'd9, 4'd0, 4'd6, 4'd0, 16'h0020), 0, 16'h0005);
    check("lat_lod_wait", 64'(t_fetch - t_last), 64'd10);
    mem(1'b1, 16'h0020, 32'h8000_0000, 32'h0, 0);

    // SUB of equal values, conditional branches
    fetch(enc(4'd2, 4'd0, 4'd3, 4'd0, 16'h0005), 0, 16'h0006);
    fetch(enc(4'd2, 4'd0, 4'd4, 4'd0, 16'h0005), 0, 16'h0007);
    fetch(enc(4'd1, 4'd1, 4'd5, 4'd3, 16'h4000), 0, 16'h0008);
    wait_n(2);
    check("stat_sub_eq", {60'd0, stat_out}, {60'd0, 4'b0001});
    fetch(enc(4'd4, 4'd2, 4'd0, 4'd0, 16'h1234), 0, 16'h0009);
    fetch(enc(4'd5, 4'd1, 4'd0, 4'd0, 16'hFFFD), 0, 16'h000A);
    check("lat_bra_nt", 64'(t_fetch - t_last), 64'd3);
    fetch(enc(4'd9, 4'd0, 4'd5, 4'd0, 16'h0030), 0, 16'h0008);
    check("lat_brr", 64'(t_fetch - t_last), 64'd3);
    mem(1'b1, 16'h0030, 32'h0000_0000, 32'h0, 0);

    // R0 / out-of-range writes dropped, PC wraps past 0xFFFF
    fetch(enc(4'd4, 4'd0, 4'd0, 4'd0, 16'hFFFE), 0, 16'h0009);
    fetch(enc(4'd2, 4'd0, 4'd0, 4'd0, 16'h0007), 0, 16'hFFFE);
    fetch(enc(4'd2, 4'd0, 4'd8, 4'd0, 16'h0009), 0, 16'hFFFF);
    fetch(enc(4'd9, 4'd0, 4'd0, 4'd0, 16'h0040), 0, 16'h0000);
    mem(1'b1, 16'h0040, 32'h0000_0000, 32'h0, 0);
    fetch(enc(4'd9, 4'd0, 4'd8, 4'd0, 16'h0041), 0, 16'h0001);
    mem(1'b1, 16'h0041, 32'h0000_0000, 32'h0, 0);
    fetch(enc(4'd15, 4'd0, 4'd0, 4'd0, 16'h0000), 0, 16'h0002);
    wait_n(2);
    for (int i = 0; i < 4; i++) begin
      check("halt_held", {61'd0, halted, imem_req, dmem_req}, {61'd0, 3'b100});
      @(negedge clk);
    end

    // Reset while a load is waiting for dmem_ready
    rst_f = 1'b1;
    @(negedge clk);
    rst_f = 1'b0;
    fetch(enc(4'd2, 4'd0, 4'd1, 4'd0, 16'hFFFF), 0, 16'h0000);
    wait_n(2);
    check("stat_before_rst", {60'd0, stat_out}, {60'd0, 4'b0010});
    fetch(enc(4'd8, 4'd0, 4'd1, 4'd0, 16'h0050), 0, 16'h0001);
    begin
      int n;
      n = 0;
      while (dmem_req !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    check("lod_pending", {63'd0, dmem_req}, 64'd1);
    rst_f = 1'b1;
    @(negedge clk);
    check("midmem_rst_req", {61'd0, dmem_req, imem_req, halted}, 64'd0);
    check("midmem_rst_pc", {48'd0, imem_addr}, 64'd0);
    check("midmem_rst_stat", {60'd0, stat_out}, 64'd0);
    rst_f = 1'b0;
    fetch(enc(4'd9, 4'd0, 4'd1, 4'd0, 16'h0060), 0, 16'h0000);
    mem(1'b1, 16'h0060, 32'h0000_0000, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
